// File: rtl/tinker_mem_responder_if.sv
// Request/response bundle between the tinker core ports and the memory responder.
// Fetch and load/store channels share one interface; the responder takes the slave side.
interface tinker_mem_responder_if;
   logic        if_req_valid;
   logic        if_req_ready;
   logic [63:0] if_addr;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        if_rsp_err;
   logic        d_req_valid;
   logic        d_req_ready;
   logic        d_req_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_rsp_valid;
   logic [63:0] d_rsp_rdata;
   logic        d_rsp_err;

   modport master (
      output if_req_valid, if_addr,
      output d_req_valid, d_req_we, d_addr, d_wdata,
      input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
   );

   modport slave (
      input  if_req_valid, if_addr,
      input  d_req_valid, d_req_we, d_addr, d_wdata,
      output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
   );
endinterface

// File: rtl/tinker_mem_responder.sv
// Fixed-latency byte-addressed little-endian memory serving fetch and data ports.
// One request in flight; data wins arbitration when both channels request together.
module tinker_mem_responder #(
   parameter int ADDR_W  = 19,
   parameter int LATENCY = 2
) (
   input logic                   clk,
   input logic                   reset,
   tinker_mem_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [64:0] LIMIT = (65'd1 << ADDR_W) - 65'd1;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   logic [7:0] mem [2**ADDR_W];

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ch_q, ch_d;
   logic        we_q, we_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;

   logic              if_rdy, d_rdy;
   logic              resp, err, wr_en;
   logic [64:0]       last_addr;
   logic [ADDR_W-1:0] base;
   logic [63:0]       rd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ch_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if_rdy  = 1'b0;
      d_rdy   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if_rdy = ~bus.d_req_valid;
            d_rdy  = 1'b1;
            if (bus.d_req_valid) begin
               ch_d    = 1'b1;
               we_d    = bus.d_req_we;
               addr_d  = bus.d_addr;
               wdata_d = bus.d_wdata;
               cnt_d   = CNT_INIT;
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end else if (bus.if_req_valid) begin
               ch_d    = 1'b0;
               we_d    = 1'b0;
               addr_d  = bus.if_addr;
               wdata_d = '0;
               cnt_d   = CNT_INIT;
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Range check in 65 bits so addresses near 2**64 cannot wrap into range.
   assign resp      = (state_q == RESP);
   assign last_addr = {1'b0, addr_q} + (ch_q ? 65'd7 : 65'd3);
   assign err       = last_addr > LIMIT;
   assign base      = addr_q[ADDR_W-1:0];
   assign wr_en     = resp & ch_q & we_q & ~err & ~reset;

   always_comb begin
      rd = '0;
      for (int k = 0; k < 8; k++)
         rd[8*k +: 8] = mem[base + ADDR_W'(k)];
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         for (int k = 0; k < 8; k++)
            mem[base + ADDR_W'(k)] <= wdata_q[8*k +: 8];
   end

   assign bus.if_req_ready = if_rdy & ~reset;
   assign bus.d_req_ready  = d_rdy & ~reset;
   assign bus.if_rsp_valid = resp & ~ch_q;
   assign bus.if_rsp_err   = resp & ~ch_q & err;
   assign bus.if_rsp_data  = (resp & ~ch_q & ~err) ? rd[31:0] : 32'd0;
   assign bus.d_rsp_valid  = resp & ch_q;
   assign bus.d_rsp_err    = resp & ch_q & err;
   assign bus.d_rsp_rdata  = (resp & ch_q & ~we_q & ~err) ? rd : 64'd0;

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Directed checks of the memory responder at latency 2 and latency 1.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_tinker_mem_responder;

   logic clk = 1'b0;
   logic reset;
   int   ncmp = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   tinker_mem_responder_if b2 ();
   tinker_mem_responder_if b1 ();

   tinker_mem_responder #(.ADDR_W(19), .LATENCY(2)) dut2 (
      .clk(clk), .reset(reset), .bus(b2.slave)
   );
   tinker_mem_responder #(.ADDR_W(19), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .bus(b1.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      b2.if_req_valid = 0; b2.if_addr = 0; b2.d_req_valid = 0;
      b2.d_req_we = 0; b2.d_addr = 0; b2.d_wdata = 0;
      b1.if_req_valid = 0; b1.if_addr = 0; b1.d_req_valid = 0;
      b1.d_req_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
      reset = 1;
      dut2.mem[32'h2000] = 8'h78;
      dut2.mem[32'h2001] = 8'h56;
      dut2.mem[32'h2002] = 8'h34;
      dut2.mem[32'h2003] = 8'h12;
      for (int i = 0; i < 8; i++) dut2.mem[32'h3000 + i] = 8'h5A;
      for (int i = 0; i < 16; i++) dut1.mem[32'h100 + i] = 8'(i);
      tick();
      tick();
      chk("rst_d_ready", 64'(b2.d_req_ready), 0);
      chk("rst_if_ready", 64'(b2.if_req_ready), 0);
      chk("rst_d_valid", 64'(b2.d_rsp_valid), 0);
      chk("rst_if_valid", 64'(b2.if_rsp_valid), 0);
      reset = 0;
      #1;
      chk("idle_d_ready", 64'(b2.d_req_ready), 1);
      chk("idle_if_ready", 64'(b2.if_req_ready), 1);

      // 1: fetch at latency 2
      b2.if_req_valid = 1; b2.if_addr = 64'h2000;
      tick();
      b2.if_req_valid = 0;
      chk("f1_wait_valid", 64'(b2.if_rsp_valid), 0);
      chk("f1_wait_ready", 64'(b2.if_req_ready), 0);
      tick();
      chk("f1_valid", 64'(b2.if_rsp_valid), 1);
      chk("f1_data", 64'(b2.if_rsp_data), 64'h12345678);
      chk("f1_err", 64'(b2.if_rsp_err), 0);
      chk("f1_resp_ready", 64'(b2.d_req_ready), 0);
      tick();
      chk("f1_after_valid", 64'(b2.if_rsp_valid), 0);
      chk("f1_after_data", 64'(b2.if_rsp_data), 0);

      // 2: store then load at the top of memory
      b2.d_req_valid = 1; b2.d_req_we = 1;
      b2.d_addr = 64'h7FFF8; b2.d_wdata = 64'h1122334455667788;
      tick();
      b2.d_req_valid = 0; b2.d_req_we = 0; b2.d_wdata = 0;
      tick();
      chk("st_valid", 64'(b2.d_rsp_valid), 1);
      chk("st_err", 64'(b2.d_rsp_err), 0);
      chk("st_rdata", b2.d_rsp_rdata, 0);
      tick();
      chk("st_byte0", 64'(dut2.mem[32'h7FFF8]), 64'h88);
      chk("st_byte7", 64'(dut2.mem[32'h7FFFF]), 64'h11);
      b2.d_req_valid = 1; b2.d_addr = 64'h7FFF8;
      tick();
      b2.d_req_valid = 0;
      tick();
      chk("ld_valid", 64'(b2.d_rsp_valid), 1);
      chk("ld_rdata", b2.d_rsp_rdata, 64'h1122334455667788);
      chk("ld_err", 64'(b2.d_rsp_err), 0);
      tick();

      // 3: same-cycle fetch and load, data wins
      b2.if_req_valid = 1; b2.if_addr = 64'h2000;
      b2.d_req_valid = 1; b2.d_addr = 64'h7FFF8;
      #1;
      chk("arb_if_ready", 64'(b2.if_req_ready), 0);
      chk("arb_d_ready", 64'(b2.d_req_ready), 1);
      tick();
      b2.d_req_valid = 0;
      #1;
      chk("arb_wait_if_ready", 64'(b2.if_req_ready), 0);
      tick();
      chk("arb_d_valid", 64'(b2.d_rsp_valid), 1);
      chk("arb_d_rdata", b2.d_rsp_rdata, 64'h1122334455667788);
      chk("arb_if_valid", 64'(b2.if_rsp_valid), 0);
      chk("arb_resp_if_ready", 64'(b2.if_req_ready), 0);
      tick();
      chk("arb_idle_if_ready", 64'(b2.if_req_ready), 1);
      tick();
      b2.if_req_valid = 0;
      tick();
      chk("arb_if_rsp", 64'(b2.if_rsp_valid), 1);
      chk("arb_if_data", 64'(b2.if_rsp_data), 64'h12345678);
      tick();

      // 4: out-of-range load and store
      b2.d_req_valid = 1; b2.d_addr = 64'h7FFF9;
      tick();
      b2.d_req_valid = 0;
      tick();
      chk("oor_ld_valid", 64'(b2.d_rsp_valid), 1);
      chk("oor_ld_err", 64'(b2.d_rsp_err), 1);
      chk("oor_ld_rdata", b2.d_rsp_rdata, 0);
      tick();
      b2.d_req_valid = 1; b2.d_req_we = 1;
      b2.d_addr = 64'hFFFFFFFFFFFFFFFC; b2.d_wdata = 64'hDEADBEEFCAFEF00D;
      tick();
      b2.d_req_valid = 0; b2.d_req_we = 0;
      tick();
      chk("oor_st_err", 64'(b2.d_rsp_err), 1);
      tick();
      chk("oor_st_mem_fc", 64'(dut2.mem[32'h7FFFC]), 64'h44);
      chk("oor_st_mem_ff", 64'(dut2.mem[32'h7FFFF]), 64'h11);

      // 5: reset while a store waits
      b2.d_req_valid = 1; b2.d_req_we = 1;
      b2.d_addr = 64'h3000; b2.d_wdata = 64'hA5A5A5A5A5A5A5A5;
      tick();
      b2.d_req_valid = 0; b2.d_req_we = 0;
      reset = 1;
      #1;
      chk("rw_valid0", 64'(b2.d_rsp_valid), 0);
      chk("rw_ready0", 64'(b2.d_req_ready), 0);
      tick();
      chk("rw_valid1", 64'(b2.d_rsp_valid), 0);
      tick();
      reset = 0;
      #1;
      chk("rw_ready_rel", 64'(b2.d_req_ready), 1);
      tick();
      chk("rw_valid2", 64'(b2.d_rsp_valid), 0);
      chk("rw_mem0", 64'(dut2.mem[32'h3000]), 64'h5A);
      chk("rw_mem7", 64'(dut2.mem[32'h3007]), 64'h5A);

      // 6: latency 1, back-to-back loads
      b1.d_req_valid = 1; b1.d_addr = 64'h100;
      #1;
      chk("l1_ready0", 64'(b1.d_req_ready), 1);
      tick();
      b1.d_addr = 64'h103;
      chk("l1_valid0", 64'(b1.d_rsp_valid), 1);
      chk("l1_rdata0", b1.d_rsp_rdata, 64'h0706050403020100);
      chk("l1_resp_ready", 64'(b1.d_req_ready), 0);
      tick();
      chk("l1_idle_valid", 64'(b1.d_rsp_valid), 0);
      chk("l1_idle_ready", 64'(b1.d_req_ready), 1);
      tick();
      b1.d_req_valid = 0;
      chk("l1_valid1", 64'(b1.d_rsp_valid), 1);
      chk("l1_rdata1", b1.d_rsp_rdata, 64'h0A09080706050403);
      tick();
      chk("l1_end_valid", 64'(b1.d_rsp_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
